// File: rtl/hazard_control_unit.sv
// Stall/flush controller: load-use, branch-operand, mul/div occupancy, HALT.
// Optional HAZARD_PERF_EN adds a saturating stall_cycles counter port.
module hazard_control_unit #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8,
  parameter int CW         = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] id_op1,
  input  logic [3:0] id_op2,
  input  logic       id_use1,
  input  logic       id_use2,
  input  logic       id_branch,
  input  logic       id_halt,
  input  logic       branch_taken,
  input  logic [3:0] ex_op1,
  input  logic [1:0] ex_regwrite,
  input  logic       ex_memread,
  input  logic       ex_muldiv,
  input  logic       ex_is_div,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       ifid_flush,
  output logic       idex_write,
  output logic       idex_bubble,
  output logic       exmem_bubble,
  output logic       muldiv_busy,
  output logic       halted
`ifdef HAZARD_PERF_EN
  ,
  output logic [15:0] stall_cycles
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LDBR,
    S_MULDIV,
    S_HALT
  } state_t;

  localparam logic [CW-1:0] MUL_LD = CW'(MUL_CYCLES - 2);
  localparam logic [CW-1:0] DIV_LD = CW'(DIV_CYCLES - 2);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_lu;
  logic          w_bh;
  logic          w_br_op1;

  assign w_br_op1 = id_branch & (ex_op1 == id_op1);
  assign w_lu = ex_memread &
                ((id_use1 & (ex_op1 == id_op1)) |
                 (id_use2 & (ex_op1 == id_op2)));
  assign w_bh = w_br_op1 & (ex_regwrite == 2'b11);

  // State and occupancy counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state and pipeline controls; reset forces a bubbling pipe
  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_write   = 1'b1;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    muldiv_busy  = 1'b0;
    halted       = 1'b0;
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (ex_muldiv) begin
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          idex_write   = 1'b0;
          exmem_bubble = 1'b1;
          muldiv_busy  = 1'b1;
          w_cnt_nxt    = ex_is_div ? DIV_LD : MUL_LD;
          w_state_nxt  = S_MULDIV;
        end else if (w_lu) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          if (w_br_op1) w_state_nxt = S_LDBR;
        end else if (w_bh) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
        end else if (id_halt) begin
          w_state_nxt = S_HALT;
        end else if (branch_taken) begin
          ifid_flush = 1'b1;
        end
      end
      S_LDBR: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_MULDIV: begin
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        idex_write   = 1'b0;
        exmem_bubble = 1'b1;
        muldiv_busy  = 1'b1;
        if (r_cnt == '0) w_state_nxt = S_IDLE;
        else w_cnt_nxt = r_cnt - CW'(1);
      end
      S_HALT: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        halted      = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (!rst_n) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      ifid_flush   = 1'b0;
      idex_write   = 1'b1;
      idex_bubble  = 1'b1;
      exmem_bubble = 1'b1;
      muldiv_busy  = 1'b0;
      halted       = 1'b0;
      w_state_nxt  = S_IDLE;
      w_cnt_nxt    = '0;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [15:0] r_stall;

  // Saturating count of stalled cycles, excluding the halted state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall <= '0;
    end else if (!pc_write && r_state != S_HALT &&
                 r_stall != 16'hFFFF) begin
      r_stall <= r_stall + 16'd1;
    end
  end

  assign stall_cycles = r_stall;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Random + directed bench for hazard_control_unit against a
// cycle-count reference model.
module tb_hazard_control_unit;

  localparam int MUL = 4;
  localparam int DIV = 8;

  localparam logic [7:0] O_DFLT  = 8'hD0;
  localparam logic [7:0] O_FLUSH = 8'hF0;
  localparam logic [7:0] O_RST   = 8'h1C;
  localparam logic [7:0] O_BUSY  = 8'h06;
  localparam logic [7:0] O_STALL = 8'h18;
  localparam logic [7:0] O_HALT  = 8'h19;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] id_op1, id_op2, ex_op1;
  logic       id_use1, id_use2, id_branch, id_halt;
  logic       branch_taken;
  logic [1:0] ex_regwrite;
  logic       ex_memread, ex_muldiv, ex_is_div;
  logic       pc_write, ifid_write, ifid_flush, idex_write;
  logic       idex_bubble, exmem_bubble, muldiv_busy, halted;
`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cycles;
`endif

  always #5 clk = ~clk;

  hazard_control_unit #(
    .MUL_CYCLES(MUL),
    .DIV_CYCLES(DIV),
    .CW(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .id_op1(id_op1),
    .id_op2(id_op2),
    .id_use1(id_use1),
    .id_use2(id_use2),
    .id_branch(id_branch),
    .id_halt(id_halt),
    .branch_taken(branch_taken),
    .ex_op1(ex_op1),
    .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread),
    .ex_muldiv(ex_muldiv),
    .ex_is_div(ex_is_div),
    .pc_write(pc_write),
    .ifid_write(ifid_write),
    .ifid_flush(ifid_flush),
    .idex_write(idex_write),
    .idex_bubble(idex_bubble),
    .exmem_bubble(exmem_bubble),
    .muldiv_busy(muldiv_busy),
    .halted(halted)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // model: remaining busy cycles, remaining extra stalls, halted
  int busy_left = 0;
  int extra     = 0;
  bit m_halt    = 0;
  int m_stall   = 0;
  int busy_run  = 0;
  int stall_run = 0;
  int flush_run = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
               $time);
    end
  endtask

  task automatic clr();
    id_op1 = 0; id_op2 = 0; ex_op1 = 0;
    id_use1 = 0; id_use2 = 0; id_branch = 0; id_halt = 0;
    branch_taken = 0; ex_regwrite = 0;
    ex_memread = 0; ex_muldiv = 0; ex_is_div = 0;
  endtask

  // check one cycle against the model, then advance to next negedge
  task automatic step();
    logic [7:0] e, got;
    bit lu, bh;
    int nb, nx;
    bit nh, inc;
    #2;
    lu = ex_memread && ((id_use1 && ex_op1 == id_op1) ||
                        (id_use2 && ex_op1 == id_op2));
    bh = id_branch && ex_regwrite == 2'b11 && ex_op1 == id_op1;
    e = O_DFLT;
    nb = busy_left; nx = extra; nh = m_halt;
    if (!rst_n) begin
      e = O_RST; nb = 0; nx = 0; nh = 0;
      busy_left = 0; extra = 0; m_halt = 0; m_stall = 0;
    end else if (busy_left > 0) begin
      e = O_BUSY; nb = busy_left - 1;
    end else if (extra > 0) begin
      e = O_STALL; nx = extra - 1;
    end else if (m_halt) begin
      e = O_HALT;
    end else if (ex_muldiv) begin
      e = O_BUSY; nb = (ex_is_div ? DIV : MUL) - 1;
    end else if (lu) begin
      e = O_STALL;
      nx = (id_branch && ex_op1 == id_op1) ? 1 : 0;
    end else if (bh) begin
      e = O_STALL;
    end else if (id_halt) begin
      nh = 1;
    end else if (branch_taken) begin
      e = O_FLUSH;
    end
    inc = rst_n && !e[7] && !m_halt;
    got = {pc_write, ifid_write, ifid_flush, idex_write,
           idex_bubble, exmem_bubble, muldiv_busy, halted};
    chk("outs", got, e);
`ifdef HAZARD_PERF_EN
    chk("stall_cycles", stall_cycles, m_stall);
`endif
    if (muldiv_busy) busy_run++;
    if (!pc_write) stall_run++;
    if (ifid_flush) flush_run++;
    @(posedge clk);
    busy_left = nb; extra = nx; m_halt = nh;
    if (inc && m_stall < 65535) m_stall++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    clr();
    rst_n = 1'b0;
    @(negedge clk);
    step();
    step();
    rst_n = 1'b1;
    step();

    // load R3, add reads R3 via op2: one stall
    do_reset();
    stall_run = 0;
    ex_memread = 1; ex_op1 = 3; id_use2 = 1; id_op2 = 3;
    step();
    clr();
    step(); step();
    chk("lu_stall_len", stall_run, 1);

    // load R5, branch on R5: two stalls, then taken flush
    stall_run = 0; flush_run = 0;
    ex_memread = 1; ex_op1 = 5; id_branch = 1; id_op1 = 5;
    id_use1 = 1; branch_taken = 1;
    step();
    ex_memread = 0;
    step();
    step();
    clr();
    step();
    chk("ldbr_stall_len", stall_run, 2);
    chk("ldbr_flush_len", flush_run, 1);

    // divide: 8 busy cycles, load-use during busy leaves no residue
    busy_run = 0; stall_run = 0;
    ex_muldiv = 1; ex_is_div = 1;
    step();
    clr();
    for (int i = 0; i < 11; i++) begin
      ex_memread = (i > 0 && i < 7);
      ex_op1 = 2; id_op1 = 2; id_use1 = (i > 0 && i < 7);
      step();
    end
    clr();
    chk("div_busy_len", busy_run, DIV);
    chk("div_stall_len", stall_run, DIV);
`ifdef HAZARD_PERF_EN
    chk("perf_sum", stall_cycles, 11);
`endif

    // multiply: 4 busy cycles
    busy_run = 0;
    ex_muldiv = 1;
    step();
    clr();
    for (int i = 0; i < 5; i++) step();
    chk("mul_busy_len", busy_run, MUL);

    // multiply cut by reset at busy cycle 2
    busy_run = 0;
    ex_muldiv = 1;
    step();
    clr();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step(); step();
    chk("mul_rst_busy", busy_run, 2);

    // halt, held until reset
    stall_run = 0;
    id_halt = 1;
    step();
    clr();
    for (int i = 0; i < 6; i++) step();
    chk("halt_stall_len", stall_run, 6);
    do_reset();
    step();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      clr();
      id_op1 = 4'($urandom_range(0, 3));
      id_op2 = 4'($urandom_range(0, 3));
      ex_op1 = 4'($urandom_range(0, 3));
      id_use1 = 1'($urandom);
      id_use2 = 1'($urandom);
      id_branch = ($urandom_range(0, 3) == 0);
      branch_taken = 1'($urandom);
      ex_regwrite = 2'($urandom);
      ex_memread = ($urandom_range(0, 2) == 0);
      ex_muldiv = ($urandom_range(0, 9) == 0);
      ex_is_div = 1'($urandom);
      id_halt = ($urandom_range(0, 40) == 0);
      rst_n = !($urandom_range(0, 150) == 0) &&
              !(m_halt && $urandom_range(0, 15) == 0);
      step();
    end
    rst_n = 1'b1;
    clr();

`ifdef HAZARD_PERF_EN
    // saturation under a permanent load-use stall
    do_reset();
    ex_memread = 1; ex_op1 = 1; id_use1 = 1; id_op1 = 1;
    for (int i = 0; i < 65545; i++) @(negedge clk);
    chk("perf_sat", stall_cycles, 16'hFFFF);
    clr();
    @(negedge clk);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
